// File: rtl/bpred_update_queue.sv
// Branch-resolution queue between execute and the perceptron predictor update port.
// In-order FIFO plus an output register with valid/stall handshake and debug counters.
module bpred_update_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [31:0]       ex_PC4,
    input  logic [31:0]       ex_target,
    input  logic              ex_dir,
    input  logic              ex_miss,
    input  logic [DATA_W-1:0] ex_data,
    output logic              q_ready,
    input  logic              soin_bpredictor_stall,
    output logic              execute_bpredictor_update,
    output logic [31:0]       execute_bpredictor_PC4,
    output logic [31:0]       execute_bpredictor_target,
    output logic              execute_bpredictor_dir,
    output logic              execute_bpredictor_miss,
    output logic [DATA_W-1:0] execute_bpredictor_data,
    input  logic [1:0]        dbg_sel,
    output logic [31:0]       dbg_out
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0]       pc4;
        logic [31:0]       target;
        logic              dir;
        logic              miss;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          ex_entry;
    entry_t          head_entry;
    entry_t          or_reg;
    logic            upd_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic [31:0]     upd_cnt_reg;
    logic [31:0]     miss_cnt_reg;
    logic            overflow_reg;

    logic            accept;
    logic            or_load;
    logic            pop;
    logic            bypass;
    logic            push;
    logic            fifo_empty;

    assign ex_entry   = '{pc4: ex_PC4, target: ex_target, dir: ex_dir,
                          miss: ex_miss, data: ex_data};
    assign head_entry = mem[rd_ptr_reg];
    assign fifo_empty = (count_reg == '0);

    // Readiness looks only at the registered count; a same-cycle pop never frees a slot early.
    assign q_ready = (count_reg < CW'(DEPTH));

    assign accept  = upd_reg && !soin_bpredictor_stall;
    assign or_load = !upd_reg || accept;
    assign pop     = or_load && !fifo_empty;
    assign bypass  = or_load && fifo_empty && ex_valid;
    assign push    = ex_valid && q_ready && !bypass;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= ex_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_reg      <= 1'b0;
            or_reg       <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            upd_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (or_load) begin
                if (pop) begin
                    or_reg  <= head_entry;
                    upd_reg <= 1'b1;
                end else if (bypass) begin
                    or_reg  <= ex_entry;
                    upd_reg <= 1'b1;
                end else begin
                    upd_reg <= 1'b0;
                end
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end

            if (accept) begin
                upd_cnt_reg <= upd_cnt_reg + 32'd1;
                if (or_reg.miss) begin
                    miss_cnt_reg <= miss_cnt_reg + 32'd1;
                end
            end

            // Dropped branch: execute ignored q_ready.
            if (ex_valid && !q_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign execute_bpredictor_update = upd_reg;
    assign execute_bpredictor_PC4    = or_reg.pc4;
    assign execute_bpredictor_target = or_reg.target;
    assign execute_bpredictor_dir    = or_reg.dir;
    assign execute_bpredictor_miss   = or_reg.miss;
    assign execute_bpredictor_data   = or_reg.data;

    always_comb begin
        dbg_out = '0;
        case (dbg_sel)
            2'd0: dbg_out = 32'(count_reg);
            2'd1: dbg_out = upd_cnt_reg;
            2'd2: dbg_out = miss_cnt_reg;
            default: dbg_out = {overflow_reg, 15'b0, 8'(rd_ptr_reg), 8'(wr_ptr_reg)};
        endcase
    end

endmodule
